// File: rtl/chan_sel_bank_loader.sv
// Channel-bin select bank loader: toggle-handshaked shadow writes, commit arming,
// atomic shadow-to-active swap on frame_sync, then a busy settle window.
module chan_sel_bank_loader #(
    parameter int unsigned NBINS      = 4,
    parameter int unsigned BIN_AW     = 2,
    parameter int unsigned DW         = 32,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic                  user_clk,
    input  logic                  user_rst_n,
    input  logic                  wr_toggle,
    input  logic [BIN_AW-1:0]     wr_bin,
    input  logic [DW-1:0]         wr_data,
    input  logic                  commit_toggle,
    input  logic                  frame_sync,
    input  logic                  clr_err,
    output logic [NBINS*DW-1:0]   ch_bin_flat,
    output logic                  load_strobe,
    output logic                  busy,
    output logic                  err_sticky,
    output logic [15:0]           commit_count,
    output logic [31:0]           status_word
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned FLAT_W = NBINS * DW;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    logic              init_done;
    logic              wr_toggle_q;
    logic              commit_toggle_q;
    logic              wr_ev;
    logic              commit_ev;
    logic              wr_in_range;
    logic              wr_ok;

    logic [FLAT_W-1:0] shadow_flat;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  settle_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              pending;
    logic              pending_nxt;
    logic              do_load;
    logic [7:0]        wr_count;

    // Toggle edge detection; the first cycle after reset only captures levels.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            init_done       <= 1'b0;
            wr_toggle_q     <= 1'b0;
            commit_toggle_q <= 1'b0;
        end else begin
            init_done       <= 1'b1;
            wr_toggle_q     <= wr_toggle;
            commit_toggle_q <= commit_toggle;
        end
    end

    assign wr_ev       = init_done & (wr_toggle ^ wr_toggle_q);
    assign commit_ev   = init_done & (commit_toggle ^ commit_toggle_q);
    assign wr_in_range = (32'(wr_bin) < NBINS);
    assign wr_ok       = wr_ev & wr_in_range;

    // Shadow bank write and write accounting, accepted in every state.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            shadow_flat <= '0;
            wr_count    <= 8'd0;
        end else if (wr_ok) begin
            for (int unsigned i = 0; i < NBINS; i++) begin
                if (32'(wr_bin) == i) begin
                    shadow_flat[i*DW +: DW] <= wr_data;
                end
            end
            wr_count <= wr_count + 8'd1;
        end
    end

    // Out-of-range writes set the sticky error; a simultaneous clear loses.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            err_sticky <= 1'b0;
        end else if (wr_ev && !wr_in_range) begin
            err_sticky <= 1'b1;
        end else if (clr_err) begin
            err_sticky <= 1'b0;
        end
    end

    // State register.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a commit seen on the last settle cycle still re-arms.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = settle_cnt;
        pending_nxt = pending;
        do_load     = 1'b0;
        case (state)
            S_IDLE: begin
                if (commit_ev) begin
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                if (frame_sync) begin
                    do_load   = 1'b1;
                    state_nxt = S_SETTLE;
                    cnt_nxt   = CNT_W'(SETTLE_CYC);
                end
            end
            S_SETTLE: begin
                if (settle_cnt <= CNT_W'(1)) begin
                    pending_nxt = 1'b0;
                    state_nxt   = (pending || commit_ev) ? S_ARMED : S_IDLE;
                end else begin
                    cnt_nxt = settle_cnt - CNT_W'(1);
                    if (commit_ev) begin
                        pending_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and status registers driven by the FSM decisions.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            settle_cnt   <= '0;
            pending      <= 1'b0;
            ch_bin_flat  <= '0;
            load_strobe  <= 1'b0;
            busy         <= 1'b0;
            commit_count <= 16'd0;
        end else begin
            settle_cnt  <= cnt_nxt;
            pending     <= pending_nxt;
            load_strobe <= do_load;
            busy        <= (state_nxt != S_IDLE);
            if (do_load) begin
                ch_bin_flat  <= shadow_flat;
                commit_count <= commit_count + 16'd1;
            end
        end
    end

    assign status_word = {busy, pending, err_sticky, 5'b0, wr_count, commit_count};

endmodule

// File: tb/tb_chan_sel_bank_loader.sv
// Bench for chan_sel_bank_loader: two parameterisations driven by shared stimulus,
// checked every cycle against a behavioural model plus directed literal checks.
module tb_chan_sel_bank_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_toggle;
    logic [2:0]   wr_bin;
    logic [31:0]  wr_data;
    logic         commit_toggle;
    logic         frame_sync;
    logic         clr_err;

    logic [127:0] flat_a;
    logic         ls_a, busy_a, err_a;
    logic [15:0]  cc_a;
    logic [31:0]  st_a;
    logic [95:0]  flat_b;
    logic         ls_b, busy_b, err_b;
    logic [15:0]  cc_b;
    logic [31:0]  st_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    chan_sel_bank_loader #(.NBINS(4), .BIN_AW(3), .DW(32), .SETTLE_CYC(8)) u_a (
        .user_clk(clk), .user_rst_n(rst_n), .wr_toggle(wr_toggle), .wr_bin(wr_bin),
        .wr_data(wr_data), .commit_toggle(commit_toggle), .frame_sync(frame_sync),
        .clr_err(clr_err), .ch_bin_flat(flat_a), .load_strobe(ls_a), .busy(busy_a),
        .err_sticky(err_a), .commit_count(cc_a), .status_word(st_a)
    );

    chan_sel_bank_loader #(.NBINS(3), .BIN_AW(2), .DW(32), .SETTLE_CYC(3)) u_b (
        .user_clk(clk), .user_rst_n(rst_n), .wr_toggle(wr_toggle), .wr_bin(wr_bin[1:0]),
        .wr_data(wr_data), .commit_toggle(commit_toggle), .frame_sync(frame_sync),
        .clr_err(clr_err), .ch_bin_flat(flat_b), .load_strobe(ls_b), .busy(busy_b),
        .err_sticky(err_b), .commit_count(cc_b), .status_word(st_b)
    );

    // ---------------- behavioural model ----------------
    int          nb[2]  = '{4, 3};
    int          stl[2] = '{8, 3};
    bit          m_init[2], m_wq[2], m_cq[2], m_load[2], m_pend[2], m_err[2];
    int          m_phase[2];   // 0 idle, 1 waiting for frame, 2 settling
    int          m_left[2];    // busy cycles still to show in the settle window
    logic [15:0] m_cc[2];
    logic [7:0]  m_wc[2];
    logic [31:0] m_sh[2][4];
    logic [31:0] m_act[2][4];

    task automatic model_step(input int k);
        bit we, ce;
        int bin;
        if (!rst_n) begin
            m_init[k] = 0; m_wq[k] = 0; m_cq[k] = 0; m_load[k] = 0; m_pend[k] = 0;
            m_err[k] = 0; m_phase[k] = 0; m_left[k] = 0; m_cc[k] = '0; m_wc[k] = '0;
            for (int i = 0; i < 4; i++) begin
                m_sh[k][i] = '0;
                m_act[k][i] = '0;
            end
            return;
        end
        we = m_init[k] && (wr_toggle != m_wq[k]);
        ce = m_init[k] && (commit_toggle != m_cq[k]);
        m_wq[k] = wr_toggle;
        m_cq[k] = commit_toggle;
        m_init[k] = 1;
        bin = (k == 0) ? int'(wr_bin) : int'(wr_bin[1:0]);
        m_load[k] = 0;
        if (m_phase[k] == 0) begin
            if (ce) m_phase[k] = 1;
        end else if (m_phase[k] == 1) begin
            if (frame_sync) begin
                for (int i = 0; i < nb[k]; i++) m_act[k][i] = m_sh[k][i];
                m_load[k] = 1;
                m_cc[k] = m_cc[k] + 16'd1;
                m_phase[k] = 2;
                m_left[k] = stl[k];
            end
        end else begin
            if (m_left[k] == 1) begin
                m_phase[k] = (m_pend[k] || ce) ? 1 : 0;
                m_pend[k] = 0;
            end else begin
                m_left[k] = m_left[k] - 1;
                if (ce) m_pend[k] = 1;
            end
        end
        if (we && bin < nb[k]) begin
            m_sh[k][bin] = wr_data;
            m_wc[k] = m_wc[k] + 8'd1;
        end
        if (we && bin >= nb[k]) m_err[k] = 1;
        else if (clr_err) m_err[k] = 0;
    endtask

    function automatic logic [127:0] exp_flat(input int k);
        logic [127:0] e;
        e = '0;
        for (int i = 0; i < nb[k]; i++) e[i*32 +: 32] = m_act[k][i];
        return e;
    endfunction

    function automatic logic [31:0] exp_status(input int k);
        return {(m_phase[k] != 0), m_pend[k], m_err[k], 5'b0, m_wc[k], m_cc[k]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, sampled just after the edge.
    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #1;
        chk("a_flat", flat_a, exp_flat(0));
        chk("a_strobe", ls_a, m_load[0]);
        chk("a_busy", busy_a, m_phase[0] != 0);
        chk("a_err", err_a, m_err[0]);
        chk("a_count", cc_a, m_cc[0]);
        chk("a_status", st_a, exp_status(0));
        chk("b_flat", flat_b, exp_flat(1));
        chk("b_strobe", ls_b, m_load[1]);
        chk("b_busy", busy_b, m_phase[1] != 0);
        chk("b_err", err_b, m_err[1]);
        chk("b_count", cc_b, m_cc[1]);
        chk("b_status", st_b, exp_status(1));
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_wr(input logic [2:0] bin, input logic [31:0] data);
        wr_bin = bin;
        wr_data = data;
        wr_toggle = ~wr_toggle;
        @(negedge clk);
    endtask

    task automatic do_commit();
        commit_toggle = ~commit_toggle;
        @(negedge clk);
    endtask

    task automatic do_frame();
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_toggle = 1'b1;
        commit_toggle = 1'b1;
        wr_bin = '0;
        wr_data = '0;
        frame_sync = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Toggles held high across reset must not create events.
        repeat (20) begin
            @(negedge clk);
            chk("t1_flat", flat_a, 128'd0);
            chk("t1_busy", busy_a, 1'b0);
        end

        // Basic load and settle window.
        do_wr(3'd0, 32'h11);
        do_wr(3'd1, 32'h22);
        do_wr(3'd2, 32'h33);
        do_wr(3'd3, 32'h44);
        do_commit();
        do_frame();
        chk("t2_flat", flat_a, 128'h00000044_00000033_00000022_00000011);
        chk("t2_strobe_hi", ls_a, 1'b1);
        chk("t2_count", cc_a, 16'd1);
        chk("t2_busy_t1", busy_a, 1'b1);
        @(negedge clk);
        chk("t2_strobe_lo", ls_a, 1'b0);
        chk("t2_busy_t2", busy_a, 1'b1);
        repeat (6) begin
            @(negedge clk);
            chk("t2_busy_hold", busy_a, 1'b1);
        end
        @(negedge clk);
        chk("t2_busy_end", busy_a, 1'b0);

        // Write coinciding with frame_sync lands after the swap.
        do_commit();
        wr_bin = 3'd2;
        wr_data = 32'hAA;
        wr_toggle = ~wr_toggle;
        do_frame();
        chk("t3_old_bin2", flat_a[95:64], 96'h33);
        repeat (8) @(negedge clk);
        do_commit();
        do_frame();
        chk("t3_new_bin2", flat_a[95:64], 96'hAA);
        repeat (8) @(negedge clk);

        // Two commits during settle coalesce into one re-arm.
        do_commit();
        do_frame();
        do_commit();
        do_commit();
        repeat (6) @(negedge clk);
        chk("t4_rearmed", busy_a, 1'b1);
        chk("t4_count_mid", cc_a, 16'd4);
        do_frame();
        chk("t4_count_load", cc_a, 16'd5);
        repeat (20) @(negedge clk);
        chk("t4_count_final", cc_a, 16'd5);
        chk("t4_idle", busy_a, 1'b0);

        // Out-of-range write on the three-bin instance.
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t5_cleared0", err_b, 1'b0);
        do_wr(3'd3, 32'hDEAD);
        chk("t5_err", err_b, 1'b1);
        chk("t5_status29", st_b[29], 1'b1);
        chk("t5_bins_kept", flat_b, 96'h000000AA_00000022_00000011);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t5_cleared", err_b, 1'b0);
        clr_err = 1'b1;
        do_wr(3'd3, 32'hBEEF);
        clr_err = 1'b0;
        chk("t5_set_wins", err_b, 1'b1);

        // Asynchronous reset in the middle of settle with a pending commit.
        do_commit();
        do_frame();
        do_commit();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_flat", flat_a, 128'd0);
        chk("t6_busy", busy_a, 1'b0);
        chk("t6_count", cc_a, 16'd0);
        chk("t6_status", st_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("t6_idle", busy_a, 1'b0);
        chk("t6_nopend", st_a[30], 1'b0);

        // Randomised traffic checked by the model.
        repeat (4000) begin
            rst_n = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 3) == 0) begin
                wr_bin = 3'($urandom_range(0, 7));
                wr_data = $urandom;
                wr_toggle = ~wr_toggle;
            end
            if ($urandom_range(0, 9) == 0) commit_toggle = ~commit_toggle;
            frame_sync = ($urandom_range(0, 4) == 0);
            clr_err = ($urandom_range(0, 29) == 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        frame_sync = 1'b0;
        clr_err = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chan_sel_bank_loader.md
Name: chan_sel_bank_loader

Overview:
- Sequences software channel-bin selections into the channel-select datapath.
- Software writes selections into shadow registers through toggle-handshaked register words, then issues a commit.
- The block swaps all active bins atomically on the next frame_sync, then holds busy for a settle period while the downstream selector pipeline flushes.
- Sits between the ppc2simulink register outputs and the chan_sel bin-select inputs, in the user clock domain.

Parameters:
- NBINS, 4, number of channel-bin select registers managed (2..16).
- BIN_AW, 2, width of the bin index; 2**BIN_AW >= NBINS.
- DW, 32, width of one bin-select word.
- SETTLE_CYC, 8, cycles busy stays high after a load; legal range 1..255.

Ports:
- user_clk  in  1  sole clock.
- user_rst_n  in  1  asynchronous, active-low reset.
- wr_toggle  in  1  any change in level requests one shadow write.
- wr_bin  in  BIN_AW  shadow index for the write.
- wr_data  in  DW  shadow write data.
- commit_toggle  in  1  any change in level requests a commit.
- frame_sync  in  1  single-cycle frame boundary pulse.
- clr_err  in  1  level; clears err_sticky.
- ch_bin_flat  out  NBINS*DW  active selections; bin i occupies bits [i*DW +: DW].
- load_strobe  out  1  one-cycle pulse in the first cycle new values are active.
- busy  out  1  high in ARMED and SETTLE.
- err_sticky  out  1  set by a write with wr_bin >= NBINS.
- commit_count  out  16  number of completed loads; wraps.
- status_word  out  32  {busy, pending, err_sticky, 5'b0, wr_count[7:0], commit_count[15:0]}.

Behaviour:
- Reset (async assert, sync release):
  - all shadow and active words 0, so ch_bin_flat = 0;
  - load_strobe, busy, err_sticky, pending = 0;
  - commit_count and wr_count = 0;
  - state IDLE.
- Toggle detect:
  - wr_toggle_q and commit_toggle_q register the inputs.
  - An event occurs in cycle t when input != _q.
  - First cycle after reset release: an init flag loads _q from the inputs and suppresses events, so a toggle held at 1 across reset gives no spurious event.
- Shadow write:
  - On a wr event in cycle t with wr_bin < NBINS, shadow[wr_bin] = wr_data, visible from t+1; wr_count++ (8-bit, wraps).
  - If wr_bin >= NBINS, no write occurs and err_sticky is set at t+1.
  - Writes are accepted in every state.
- State machine:
  - IDLE: commit event -> ARMED.
  - ARMED: frame_sync in cycle t -> active <= shadow (values as of the start of t), so ch_bin_flat changes at t+1; load_strobe = 1 at t+1; commit_count++; go to SETTLE with counter = SETTLE_CYC.
  - SETTLE: counter decrements each cycle; busy is high for exactly SETTLE_CYC cycles, t+1 through t+SETTLE_CYC. On exit, pending=1 -> ARMED and clear pending; otherwise -> IDLE.
- Simultaneous and boundary events:
  - wr event and frame_sync in the same cycle t while ARMED: the load uses the old shadow; the new data stays in shadow for the next commit.
  - Commit event and frame_sync in the same cycle in IDLE: no load; go to ARMED and wait for the next frame_sync.
  - Commit event in ARMED: coalesced, no extra load.
  - Commit event in SETTLE: sets pending (at most one outstanding).
  - frame_sync in IDLE or SETTLE: ignored.
  - Active words never change except on a load.
- clr_err and an error write in the same cycle: set wins.
- commit_count wraps 0xFFFF -> 0x0000.
- Reset asserted mid-SETTLE or mid-ARMED: immediate return to reset values; pending is lost.

Test Plan:
1. Reset with wr_toggle=1 and commit_toggle=1 held, then release -> no write and no ARMED; ch_bin_flat=0, busy=0 for 20 cycles.
2. Write bin0..3 = 0x11,0x22,0x33,0x44, toggle commit, frame_sync at t:
   - ch_bin_flat = {0x44,0x33,0x22,0x11} at t+1;
   - load_strobe is a single pulse at t+1;
   - busy high through t+8, low at t+9;
   - commit_count = 1.
3. ARMED with bin2 shadow = 0x33; write bin2 = 0xAA in the same cycle as frame_sync -> active bin2 = 0x33, shadow = 0xAA. Second commit plus frame_sync -> bin2 = 0xAA.
4. Commit toggled twice during SETTLE -> exactly one re-arm; the next frame_sync gives one more load; commit_count increases by 2 total, not 3.
5. Write with wr_bin = 3 when NBINS=3 -> no bin changes; err_sticky = 1 and status_word[29] = 1. clr_err pulse -> err_sticky = 0.
6. Assert user_rst_n low mid-SETTLE -> outputs are zero immediately (asynchronous); after release the block is in IDLE with pending cleared.
